// File: rtl/sdram_arbiter_pkg.sv
// Shared types and default sizing for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int PORTS_DEF   = 3;   // 0 = CHR, 1 = PRG, 2 = loader
  localparam int ADDR_W      = 22;  // word address width
  localparam int DATA_W      = 16;  // data width
  localparam int TIMEOUT_DEF = 255; // watchdog limit, fits the 8-bit counter

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One latched request per port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
// slave = arbiter view, master = clients + SDRAM controller view.
interface sdram_arbiter_if import sdram_arb_pkg::*; #(
  parameter int PORTS = PORTS_DEF
);
  logic [PORTS-1:0]             port_req;
  logic [PORTS-1:0]             port_we;
  logic [PORTS-1:0][ADDR_W-1:0] port_addr;
  logic [PORTS-1:0][DATA_W-1:0] port_wdata;
  logic [PORTS-1:0][DATA_W-1:0] port_rdata;
  logic [PORTS-1:0]             port_ack;
  logic [PORTS-1:0]             port_pending;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_ack;
  logic                         timeout;

  modport slave (
    input  port_req, port_we, port_addr, port_wdata, mem_rdata, mem_ack,
    output port_rdata, port_ack, port_pending, mem_req, mem_we, mem_addr,
           mem_wdata, timeout
  );

  modport master (
    output port_req, port_we, port_addr, port_wdata, mem_rdata, mem_ack,
    input  port_rdata, port_ack, port_pending, mem_req, mem_we, mem_addr,
           mem_wdata, timeout
  );
endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin winner search starting just after last_i.
module rr_pick #(
  parameter int PORTS = 3,
  parameter int IDX_W = 2
) (
  input  logic [PORTS-1:0] pending_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);
  int cand;

  // Scan from the farthest offset back to the nearest so the nearest pending port wins.
  always_comb begin
    valid_o = |pending_i;
    idx_o   = '0;
    cand    = 0;
    for (int off = PORTS; off >= 1; off--) begin
      cand = int'(last_i) + off;
      if (cand >= PORTS) cand = cand - PORTS;
      if (pending_i[cand[IDX_W-1:0]]) idx_o = cand[IDX_W-1:0];
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between requesters,
// one transaction in flight, with a watchdog against a stuck controller.
module sdram_arbiter import sdram_arb_pkg::*; #(
  parameter int PORTS   = PORTS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);
  localparam int         IDX_W     = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  slot_t                        slot_all [PORTS];
  state_t                       state_q;
  logic [PORTS-1:0]             pending_q;
  logic [PORTS-1:0]             ack_q;
  logic [IDX_W-1:0]             last_q;   // doubles as the current grant while BUSY
  logic [7:0]                   wdog_q;
  logic                         relatch_q; // granted port re-requested during its transaction
  logic                         mem_req_q;
  logic                         mem_we_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic [DATA_W-1:0]            mem_wdata_q;
  logic [PORTS-1:0][DATA_W-1:0] rdata_q;
  logic                         timeout_q;
  logic                         pick_valid;
  logic [IDX_W-1:0]             pick_idx;
  logic                         complete;
  logic [PORTS-1:0]             clr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_slot
      slot_t slot_q;
      // Latest request wins; the granted copy already lives in mem_* so overwriting is safe.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                   slot_q <= '0;
        else if (bus.port_req[gi]) slot_q <= '{we:    bus.port_we[gi],
                                               addr:  bus.port_addr[gi],
                                               wdata: bus.port_wdata[gi]};
      end
      assign slot_all[gi] = slot_q;
    end
  endgenerate

  rr_pick #(.PORTS(PORTS), .IDX_W(IDX_W)) u_pick (
    .pending_i (pending_q),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  // Which pending bit the finishing transaction retires (none if the port re-requested).
  always_comb begin
    complete = (state_q == BUSY) && (bus.mem_ack || (wdog_q == WDOG_LAST));
    clr_vec  = '0;
    if (complete && !relatch_q) clr_vec[last_q] = 1'b1;
  end

  // Arbitration FSM with registered controller-side and ack outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ack_q       <= '0;
      last_q      <= IDX_W'(PORTS - 1);
      wdog_q      <= '0;
      relatch_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      ack_q     <= '0;
      pending_q <= (pending_q & ~clr_vec) | bus.port_req;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= slot_all[pick_idx].we;
            mem_addr_q  <= slot_all[pick_idx].addr;
            mem_wdata_q <= slot_all[pick_idx].wdata;
            last_q      <= pick_idx;
            wdog_q      <= '0;
            relatch_q   <= bus.port_req[pick_idx];
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.port_req[last_q]) relatch_q <= 1'b1;
          if (bus.mem_ack) begin
            ack_q[last_q] <= 1'b1;
            if (!mem_we_q) rdata_q[last_q] <= bus.mem_rdata;
            state_q <= IDLE;
          end else if (wdog_q == WDOG_LAST) begin
            ack_q[last_q] <= 1'b1;
            timeout_q     <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.port_rdata   = rdata_q;
  assign bus.port_ack     = ack_q;
  assign bus.port_pending = pending_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: read, fairness, overwrite, write, timeout, reset.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int P = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.PORTS(P)) bus();

  sdram_arbiter #(.PORTS(P), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata);
    bus.port_we[p]    = we;
    bus.port_addr[p]  = addr;
    bus.port_wdata[p] = wdata;
    bus.port_req[p]   = 1'b1;
  endtask

  task automatic req_tick();
    tick();
    bus.port_req = '0;
  endtask

  task automatic wait_mem_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic ack(input logic [DATA_W-1:0] rd);
    bus.mem_rdata = rd;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    $display("txn  ack=%b rdata=%h,%h,%h", bus.port_ack,
             bus.port_rdata[2], bus.port_rdata[1], bus.port_rdata[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int   acks_seen;
    int   reqs_seen;
    int   cnt;
    bit   stable;

    bus.port_req   = '0;
    bus.port_we    = '0;
    bus.port_addr  = '0;
    bus.port_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_ack    = 1'b0;
    do_reset();

    // Reset state
    check_val("rst_pending", 32'(bus.port_pending), 32'd0);
    check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_val("rst_timeout", 32'(bus.timeout), 32'd0);
    check_val("rst_rdata1", 32'(bus.port_rdata[1]), 32'd0);

    // Single read on port 1, ack 4 cycles after mem_req
    set_port(1, 1'b0, 22'h04000, 16'h0);
    req_tick();
    check_val("rd_pending", 32'(bus.port_pending), 32'b010);
    check_val("rd_no_req_yet", 32'(bus.mem_req), 32'd0);
    tick();
    check_val("rd_mem_req", 32'(bus.mem_req), 32'd1);
    check_val("rd_mem_addr", 32'(bus.mem_addr), 32'h04000);
    check_val("rd_mem_we", 32'(bus.mem_we), 32'd0);
    tick(); tick(); tick();
    check_val("rd_req_pulse", 32'(bus.mem_req), 32'd0);
    ack(16'hBEEF);
    check_val("rd_ack", 32'(bus.port_ack), 32'b010);
    check_val("rd_rdata", 32'(bus.port_rdata[1]), 32'hBEEF);
    check_val("rd_pend_clr", 32'(bus.port_pending), 32'd0);
    acks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.port_ack != '0) acks_seen++;
    end
    check_val("rd_no_extra_ack", 32'(acks_seen), 32'd0);
    check_val("rd_rdata_held", 32'(bus.port_rdata[1]), 32'hBEEF);

    // Fairness: two rounds of simultaneous requests, immediate acks
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < P; p++) set_port(p, 1'b0, 22'(32'h100 + p), 16'h0);
      req_tick();
      check_val($sformatf("fair%0d_pending", r), 32'(bus.port_pending), 32'b111);
      for (int k = 0; k < P; k++) begin
        wait_mem_req($sformatf("fair%0d_req%0d", r, k));
        check_val($sformatf("fair%0d_order%0d", r, k), 32'(bus.mem_addr), 32'h100 + 32'(k));
        ack(16'(32'hA000 + k));
        check_val($sformatf("fair%0d_ack%0d", r, k), 32'(bus.port_ack), 32'(1 << k));
      end
    end

    // Overwrite: port 2 re-requests while port 0 is in flight
    set_port(0, 1'b0, 22'h200, 16'h0);
    req_tick();
    wait_mem_req("ow_req0");
    check_val("ow_addr0", 32'(bus.mem_addr), 32'h200);
    set_port(2, 1'b0, 22'h10, 16'h0);
    req_tick();
    set_port(2, 1'b0, 22'h20, 16'h0);
    req_tick();
    ack(16'h1111);
    check_val("ow_ack0", 32'(bus.port_ack), 32'b001);
    wait_mem_req("ow_req2");
    check_val("ow_addr2", 32'(bus.mem_addr), 32'h20);
    ack(16'h5555);
    check_val("ow_ack2", 32'(bus.port_ack), 32'b100);
    reqs_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_req) reqs_seen++;
    end
    check_val("ow_single_txn", 32'(reqs_seen), 32'd0);

    // Write on port 2 to the top address
    set_port(2, 1'b1, 22'h3FFFFF, 16'h1234);
    req_tick();
    wait_mem_req("wr_req");
    check_val("wr_we", 32'(bus.mem_we), 32'd1);
    check_val("wr_addr", 32'(bus.mem_addr), 32'h3FFFFF);
    check_val("wr_wdata", 32'(bus.mem_wdata), 32'h1234);
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 22'h3FFFFF || bus.mem_wdata !== 16'h1234)
        stable = 1'b0;
    end
    check_val("wr_stable", 32'(stable), 32'd1);
    ack(16'hDEAD);
    check_val("wr_ack", 32'(bus.port_ack), 32'b100);
    check_val("wr_rdata_keep", 32'(bus.port_rdata[2]), 32'h5555);

    // Timeout on port 0 with port 1 waiting behind it
    set_port(0, 1'b0, 22'h300, 16'h0);
    set_port(1, 1'b0, 22'h301, 16'h0);
    req_tick();
    wait_mem_req("to_req0");
    check_val("to_addr0", 32'(bus.mem_addr), 32'h300);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cnt++;
      if (bus.port_ack != '0) break;
    end
    check_val("to_latency", 32'(cnt), 32'd255);
    check_val("to_ack", 32'(bus.port_ack), 32'b001);
    check_val("to_flag", 32'(bus.timeout), 32'd1);
    check_val("to_rdata_keep", 32'(bus.port_rdata[0]), 32'h1111);
    wait_mem_req("to_req1");
    check_val("to_addr1", 32'(bus.mem_addr), 32'h301);
    ack(16'h7777);
    check_val("to_ack1", 32'(bus.port_ack), 32'b010);
    check_val("to_rdata1", 32'(bus.port_rdata[1]), 32'h7777);
    check_val("to_flag_sticky", 32'(bus.timeout), 32'd1);

    // Reset mid-BUSY, then a late ack
    set_port(1, 1'b0, 22'h400, 16'h0);
    req_tick();
    wait_mem_req("mr_req");
    tick();
    do_reset();
    ack(16'hCAFE);
    check_val("mr_no_ack", 32'(bus.port_ack), 32'd0);
    check_val("mr_timeout", 32'(bus.timeout), 32'd0);
    check_val("mr_pending", 32'(bus.port_pending), 32'd0);
    check_val("mr_mem_req", 32'(bus.mem_req), 32'd0);
    check_val("mr_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("mr_rdata", 32'({bus.port_rdata[2], bus.port_rdata[1]}), 32'd0);
    set_port(1, 1'b0, 22'h501, 16'h0);
    set_port(0, 1'b0, 22'h500, 16'h0);
    req_tick();
    wait_mem_req("mr_first_req");
    check_val("mr_first_port0", 32'(bus.mem_addr), 32'h500);
    ack(16'h0042);
    check_val("mr_first_ack", 32'(bus.port_ack), 32'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
